// File: rtl/memory_adaptor.sv
// memory_adaptor: serialises word-level fetch and load/store requests onto a byte-wide memory bus
module memory_adaptor #(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_MASK_HI = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush_pipline,
    input  logic                  request_ins_from_memory_adaptor,
    input  logic [ADDR_WIDTH-1:0] insaddr_to_be_fetched_from_memory_adaptor,
    output logic [31:0]           ins_fetched_from_memory_adaptor,
    output logic                  insfetch_task_done,
    input  logic                  data_request,
    input  logic                  data_is_write,
    input  logic [1:0]            data_width,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           data_wdata,
    output logic [31:0]           data_rdata,
    output logic                  data_task_done,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t                state_q, state_d;
    logic [2:0]            k_q, k_d, n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, cur_a;
    logic [31:0]           wdata_q, wdata_d, buf_q, buf_d;
    logic                  is_data_q, is_data_d, is_write_q, is_write_d;
    logic                  stall;
    logic [1:0]            bi;
    assign cur_a = base_q + ADDR_WIDTH'(k_q);
    assign stall = state_q == WRITE && cur_a[IO_MASK_HI -: 2] == 2'b11 && io_buffer_full;
    // while reading, the byte arriving now belongs to the address driven one cycle earlier
    assign bi = k_q[1:0] - 2'd1;
    assign mem_a = (state_q == READ || state_q == WRITE) ? cur_a : '0;
    assign mem_wr = rdy_in && state_q == WRITE && !stall;
    assign mem_dout = state_q == WRITE ? wdata_q[8*k_q[1:0] +: 8] : 8'h0;
    assign insfetch_task_done = state_q == DONE && !is_data_q && !flush_pipline;
    assign data_task_done = state_q == DONE && is_data_q && (is_write_q || !flush_pipline);
    assign ins_fetched_from_memory_adaptor = insfetch_task_done ? buf_q : 32'h0;
    assign data_rdata = data_task_done ? buf_q : 32'h0;
    // next-state: accept, step through bytes, abort reads on flush; everything holds while rdy_in is low
    always_comb begin
        state_d = state_q;
        k_d = k_q;
        n_d = n_q;
        base_d = base_q;
        wdata_d = wdata_q;
        buf_d = buf_q;
        is_data_d = is_data_q;
        is_write_d = is_write_q;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (data_request && (data_is_write || !flush_pipline)) begin
                        state_d = data_is_write ? WRITE : READ;
                        n_d = data_width == 2'd0 ? 3'd1 : data_width == 2'd1 ? 3'd2 : 3'd4;
                        base_d = data_addr;
                        wdata_d = data_wdata;
                        is_data_d = 1'b1;
                        is_write_d = data_is_write;
                        k_d = 3'd0;
                        buf_d = 32'h0;
                    end else if (request_ins_from_memory_adaptor && !flush_pipline) begin
                        state_d = READ;
                        n_d = 3'd4;
                        base_d = insaddr_to_be_fetched_from_memory_adaptor;
                        is_data_d = 1'b0;
                        is_write_d = 1'b0;
                        k_d = 3'd0;
                        buf_d = 32'h0;
                    end
                end
                READ: begin
                    if (flush_pipline) state_d = IDLE;
                    else begin
                        if (k_q != 3'd0) buf_d[8*bi +: 8] = mem_din;
                        if (k_q == n_q) state_d = DONE;
                        else k_d = k_q + 3'd1;
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        if (k_q == n_q - 3'd1) state_d = DONE;
                        else k_d = k_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // state registers with synchronous reset taking priority over rdy_in and flush
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            k_q <= 3'd0;
            n_q <= 3'd0;
            base_q <= '0;
            wdata_q <= 32'h0;
            buf_q <= 32'h0;
            is_data_q <= 1'b0;
            is_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            n_q <= n_d;
            base_q <= base_d;
            wdata_q <= wdata_d;
            buf_q <= buf_d;
            is_data_q <= is_data_d;
            is_write_q <= is_write_d;
        end
    end
endmodule
